// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg : shared types and constants for the TX packet scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam int         PKT_BYTES = 4;
  localparam logic [7:0] HDR0_DEF  = 8'hA5;
  localparam logic [7:0] HDR1_DEF  = 8'h5A;

  // Byte order on the wire: header, payload MSB, payload LSB, inverted sum.
  function automatic logic [7:0] pkt_byte(input logic [7:0]  hdr,
                                          input logic [15:0] pl,
                                          input logic [1:0]  idx);
    logic [7:0] sum;
    sum = hdr + pl[15:8] + pl[7:0];
    case (idx)
      2'd0:    return hdr;
      2'd1:    return pl[15:8];
      2'd2:    return pl[7:0];
      default: return ~sum;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_pkt_sched_if.sv
// ---------------------------------------------------------------------------
// tx_pkt_sched_if : requester and UART-transmitter signals of the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tx_pkt_sched_if;
  logic [1:0]  req;
  logic [15:0] payload0;
  logic [15:0] payload1;
  logic [1:0]  ack;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        pkt_done;

  modport master (
    output req, payload0, payload1, tx_done,
    input  ack, trmt, tx_data, busy, pkt_done
  );

  modport slave (
    input  req, payload0, payload1, tx_done,
    output ack, trmt, tx_data, busy, pkt_done
  );
endinterface

`default_nettype wire

// File: rtl/tx_pkt_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, priority flips on each used grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic prio1_q;
  logic prio1_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = prio1_q ? 2'b10 : 2'b01;
    end
  end

  // After granting requester 0, requester 1 wins the next contest.
  always_comb begin
    prio1_d = prio1_q;
    if (update_i && (grant_o != 2'b00)) begin
      prio1_d = grant_o[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio1_q <= 1'b0;
    end else begin
      prio1_q <= prio1_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_pkt_sched.sv
// ---------------------------------------------------------------------------
// tx_pkt_sched : arbitrates two requesters and streams 4-byte packets to a UART
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_pkt_sched
  import tx_sched_pkg::*;
#(
  parameter logic [7:0] HDR0       = HDR0_DEF,
  parameter logic [7:0] HDR1       = HDR1_DEF,
  parameter int         IFG_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  tx_pkt_sched_if.slave bus
);

  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX = 2'(PKT_BYTES - 1);

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [15:0] payload_q, payload_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_done_prev_q;

  logic [1:0]  grant;
  logic        arb_update;
  logic        done_rise;
  logic [1:0]  ack;
  logic        trmt;
  logic        busy;
  logic        pkt_done;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.req),
    .update_i (arb_update),
    .grant_o  (grant)
  );

  // History resets high so a level already high at grant is not a completion.
  assign done_rise = bus.tx_done & ~tx_done_prev_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    hdr_d      = hdr_q;
    payload_d  = payload_q;
    tx_data_d  = tx_data_q;
    arb_update = 1'b0;
    ack        = 2'b00;
    trmt       = 1'b0;
    pkt_done   = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          ack        = grant;
          arb_update = 1'b1;
          busy       = 1'b1;
          hdr_d      = grant[1] ? HDR1 : HDR0;
          payload_d  = grant[1] ? bus.payload1 : bus.payload0;
          byte_idx_d = 2'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = pkt_byte(hdr_q, payload_q, byte_idx_q);
        state_d   = S_SEND;
      end
      S_SEND: begin
        trmt    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          if (byte_idx_q == LAST_IDX) begin
            pkt_done = 1'b1;
            busy     = 1'b0;
            state_d  = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (IFG_CYCLES == 0) begin
              state_d = S_LOAD;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      byte_idx_q     <= 2'd0;
      gap_cnt_q      <= 16'd0;
      hdr_q          <= 8'h00;
      payload_q      <= 16'h0000;
      tx_data_q      <= 8'h00;
      tx_done_prev_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      gap_cnt_q      <= gap_cnt_d;
      hdr_q          <= hdr_d;
      payload_q      <= payload_d;
      tx_data_q      <= tx_data_d;
      tx_done_prev_q <= bus.tx_done;
    end
  end

  assign bus.ack      = ack;
  assign bus.trmt     = trmt;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy;
  assign bus.pkt_done = pkt_done;

endmodule

`default_nettype wire

// File: tb/tb_tx_pkt_sched.sv
// ---------------------------------------------------------------------------
// tb_tx_pkt_sched : directed scoreboard bench for tx_pkt_sched (IFG 16 and 0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tx_pkt_sched;

  localparam int UART_LEN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_pkt_sched_if bus ();
  tx_pkt_sched_if bus0 ();

  tx_pkt_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  tx_pkt_sched #(.IFG_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_bytes[$];
  logic [1:0] exp_ack[$];
  logic [7:0] exp0[$];
  logic [7:0] last_byte = 8'h00;
  logic [7:0] e;
  int  trmt_cnt = 0, pkt_cnt = 0, ack_cnt = 0, pos = 0;
  int  ack_cyc = 0, rise_cyc = 0, last_gap = 0;
  int  pos0 = 0, rise0 = 0, gap0 = 0, pkt0 = 0;
  int  ucnt = 0, ucnt0 = 0, hold0 = 0, hold1 = 0;
  bit  uart_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] cks(input logic [7:0] h, input logic [15:0] p);
    logic [7:0] s;
    s = h + p[15:8] + p[7:0];
    return ~s;
  endfunction

  function automatic void push_pkt(input logic [7:0] h, input logic [15:0] p);
    exp_bytes.push_back(h);
    exp_bytes.push_back(p[15:8]);
    exp_bytes.push_back(p[7:0]);
    exp_bytes.push_back(cks(h, p));
  endfunction

  // UART transmitter models: tx_done drops on trmt, rises UART_LEN cycles later.
  initial begin
    bus.tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.trmt && uart_en) begin
        bus.tx_done = 1'b0;
        ucnt = UART_LEN;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin
          bus.tx_done = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
  end

  initial begin
    bus0.tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (bus0.trmt) begin
        bus0.tx_done = 1'b0;
        ucnt0 = UART_LEN;
      end else if (ucnt0 > 0) begin
        ucnt0--;
        if (ucnt0 == 0) begin
          bus0.tx_done = 1'b1;
          rise0 = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack != 2'b00) begin
        ack_cnt++;
        if (exp_ack.size() == 0) check("unexpected_ack", bus.ack, 2'b00);
        else check("ack_order", bus.ack, exp_ack.pop_front());
        check("busy_at_grant", bus.busy, 1'b1);
        ack_cyc = cyc;
      end
      if (bus.trmt) begin
        if (exp_bytes.size() == 0) check("unexpected_trmt", bus.trmt, 1'b0);
        else begin
          e = exp_bytes.pop_front();
          check("tx_byte", bus.tx_data, e);
          last_byte = e;
        end
        if (pos == 0) check("ack_to_trmt", cyc - ack_cyc, 2);
        else last_gap = cyc - rise_cyc;
        pos = (pos + 1) % 4;
        trmt_cnt++;
      end else begin
        check("tx_data_hold", bus.tx_data, last_byte);
      end
      if (bus.pkt_done) begin
        pkt_cnt++;
        check("busy_at_pkt_done", bus.busy, 1'b0);
        check("pkt_done_pos", pos, 0);
      end
      if (bus0.trmt) begin
        if (exp0.size() == 0) check("unexpected_trmt_ifg0", bus0.trmt, 1'b0);
        else check("tx_byte_ifg0", bus0.tx_data, exp0.pop_front());
        if (pos0 != 0) gap0 = cyc - rise0;
        pos0 = (pos0 + 1) % 4;
      end
      if (bus0.pkt_done) pkt0++;
    end
  end

  // One clock step; requesters drop (or re-raise) their req after the acking edge.
  task automatic tick();
    logic [1:0] m, m0;
    @(negedge clk);
    m  = rst ? 2'b00 : bus.ack;
    m0 = rst ? 2'b00 : bus0.ack;
    @(posedge clk);
    #1;
    bus.req  = bus.req & ~m;
    bus0.req = bus0.req & ~m0;
    if (m[0] && hold0 > 0) begin hold0--; bus.req[0] = 1'b1; end
    if (m[1] && hold1 > 0) begin hold1--; bus.req[1] = 1'b1; end
  endtask

  task automatic wait_pkts(input int target, input int budget, input string tag);
    int n = 0;
    while (pkt_cnt < target && n < budget) begin tick(); n++; end
    check(tag, pkt_cnt, target);
  endtask

  task automatic wait_trmt(input int target, input int budget, input string tag);
    int n = 0;
    while (trmt_cnt < target && n < budget) begin tick(); n++; end
    check(tag, trmt_cnt, target);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    check("rst_trmt", bus.trmt, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    exp_bytes.delete();
    exp_ack.delete();
    pos = 0;
    last_byte = 8'h00;
  endtask

  initial begin
    int p0, t0, a0, n;
    bus.req = 2'b00;  bus.payload0 = 16'h0;  bus.payload1 = 16'h0;
    bus0.req = 2'b00; bus0.payload0 = 16'h0; bus0.payload1 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("reset_ack", bus.ack, 2'b00);
    check("reset_trmt", bus.trmt, 1'b0);
    check("reset_tx_data", bus.tx_data, 8'h00);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_pkt_done", bus.pkt_done, 1'b0);
    check("reset_tx_data_ifg0", bus0.tx_data, 8'h00);

    // Requester 0, spec vector
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h12);
    exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h14);
    exp_ack.push_back(2'b01);
    bus.payload0 = 16'h1234;
    bus.req = 2'b01;
    wait_pkts(1, 400, "pkt_req0");
    check("ifg16_rise_to_trmt", last_gap, 18);
    tick();
    check("busy_after_pkt", bus.busy, 1'b0);

    // Requester 1, spec vector
    exp_bytes.push_back(8'h5A); exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hA6);
    exp_ack.push_back(2'b10);
    bus.payload1 = 16'h00FF;
    bus.req = 2'b10;
    wait_pkts(2, 400, "pkt_req1");

    // Both held: strict alternation, no interleave
    bus.payload0 = 16'hC0DE;
    bus.payload1 = 16'h0042;
    push_pkt(8'hA5, 16'hC0DE); push_pkt(8'h5A, 16'h0042);
    push_pkt(8'hA5, 16'hC0DE); push_pkt(8'h5A, 16'h0042);
    exp_ack.push_back(2'b01); exp_ack.push_back(2'b10);
    exp_ack.push_back(2'b01); exp_ack.push_back(2'b10);
    hold0 = 1;
    hold1 = 1;
    bus.req = 2'b11;
    wait_pkts(6, 1600, "rr_four_pkts");
    check("ack_queue_drained", exp_ack.size(), 0);
    check("byte_queue_drained", exp_bytes.size(), 0);

    // Request withdrawn before ack is ignored
    a0 = ack_cnt;
    bus.payload0 = 16'h7E01;
    push_pkt(8'hA5, 16'h7E01);
    exp_ack.push_back(2'b01);
    bus.req = 2'b01;
    repeat (3) tick();
    bus.req[1] = 1'b1;
    repeat (5) tick();
    bus.req[1] = 1'b0;
    wait_pkts(7, 400, "pkt_with_dropped_req");
    repeat (20) tick();
    check("dropped_req_no_ack", ack_cnt, a0 + 1);

    // Reset after second byte aborts the packet
    t0 = trmt_cnt;
    bus.payload0 = 16'hBEEF;
    push_pkt(8'hA5, 16'hBEEF);
    exp_ack.push_back(2'b01);
    bus.req = 2'b01;
    wait_trmt(t0 + 2, 200, "reach_byte2");
    p0 = pkt_cnt;
    pulse_rst();
    t0 = trmt_cnt;
    repeat (40) tick();
    check("abort_no_trmt", trmt_cnt, t0);
    check("abort_no_pkt_done", pkt_cnt, p0);
    check("abort_busy", bus.busy, 1'b0);
    bus.payload0 = 16'h0102;
    push_pkt(8'hA5, 16'h0102);
    exp_ack.push_back(2'b01);
    bus.req = 2'b01;
    wait_pkts(p0 + 1, 400, "restart_pkt");

    // tx_done stuck high from grant: header goes, nothing advances
    uart_en = 1'b0;
    t0 = trmt_cnt;
    p0 = pkt_cnt;
    bus.payload1 = 16'hA0A0;
    push_pkt(8'h5A, 16'hA0A0);
    exp_ack.push_back(2'b10);
    bus.req = 2'b10;
    wait_trmt(t0 + 1, 100, "stuck_first_trmt");
    repeat (40) tick();
    check("stuck_no_advance", trmt_cnt, t0 + 1);
    check("stuck_busy", bus.busy, 1'b1);
    check("stuck_no_pkt_done", pkt_cnt, p0);
    pulse_rst();
    uart_en = 1'b1;
    repeat (20) tick();

    // Zero inter-frame gap instance
    exp0.push_back(8'hA5); exp0.push_back(8'h12);
    exp0.push_back(8'h34); exp0.push_back(8'h14);
    bus0.payload0 = 16'h1234;
    bus0.req = 2'b01;
    n = 0;
    while (pkt0 < 1 && n < 400) begin tick(); n++; end
    check("ifg0_pkt_done", pkt0, 1);
    check("ifg0_rise_to_trmt", gap0, 2);
    check("ifg0_queue_drained", exp0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
